uart_frame_ctrl: RTL and testbench

Byte-level frame controller that sits directly behind `uart_recv`. It sequences the receiver's `uart_done`/`uart_data` byte strobes into command frames, checks each frame's length and XOR checksum, and aborts on inter-byte timeout. It buffers the payload and presents a complete, validated frame to the downstream command decoder through a valid/ready handshake.

---
 rtl/uart_frame_ctrl_pkg.sv | 25 ++
 rtl/uart_frame_buf.sv | 28 ++
 rtl/uart_frame_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_uart_frame_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_ctrl_pkg.sv
// Shared constants and state encoding for the UART frame controller.
package uart_frame_ctrl_pkg;

    // Start-of-frame marker that opens every command frame.
    localparam logic [7:0] FRM_SOF = 8'hA5;

    // One UART character: start bit, 8 data bits, stop bit.
    localparam int BITS_PER_CHAR = 10;

    // FSM encoding, kept as plain constants so older tools and
    // waveform scripts that expect raw codes keep working.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_CMD     = 3'd1;
    localparam state_t ST_LEN     = 3'd2;
    localparam state_t ST_PAYLOAD = 3'd3;
    localparam state_t ST_CHK     = 3'd4;
    localparam state_t ST_HOLD    = 3'd5;

    // Number of clock cycles spanned by a given count of characters.
    function automatic int char_cycles(input int clk_freq, input int bps, input int chars);
        return (clk_freq / bps) * BITS_PER_CHAR * chars;
    endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: one synchronous write port, one combinational read port.
module uart_frame_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem_q [DEPTH];

    // Store one payload byte per write strobe.
    // NOTE: the array has no reset on purpose; a cleared buffer is never
    // observed (reads are qualified by frm_len) and a reset would turn the
    // storage into a large reset-fanout flop bank instead of plain memory.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_frame_ctrl.sv
// Sequences uart_recv byte strobes into checked command frames and holds
// each validated frame until the downstream decoder accepts it.
module uart_frame_ctrl
    import uart_frame_ctrl_pkg::*;
#(
    parameter int CLK_FREQ      = 50000000,
    parameter int UART_BPS      = 115200,
    parameter int MAX_LEN       = 16,
    parameter int TIMEOUT_BYTES = 4
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst,
    input  logic                         uart_done,
    input  logic [7:0]                   uart_data,
    output logic                         frm_valid,
    input  logic                         frm_ready,
    output logic [7:0]                   frm_cmd,
    output logic [$clog2(MAX_LEN+1)-1:0] frm_len,
    input  logic [$clog2(MAX_LEN)-1:0]   rd_addr,
    output logic [7:0]                   rd_data,
    output logic                         busy,
    output logic                         err_cksum,
    output logic                         err_len,
    output logic                         err_timeout,
    output logic                         err_overrun
);

    localparam int LW     = $clog2(MAX_LEN + 1);
    localparam int AW     = $clog2(MAX_LEN);
    localparam int TO_CYC = char_cycles(CLK_FREQ, UART_BPS, TIMEOUT_BYTES);
    localparam int CW     = $clog2(TO_CYC);

    localparam logic [7:0]    MAX_LEN8 = 8'(MAX_LEN);
    localparam logic [CW-1:0] TO_LAST  = CW'(TO_CYC - 1);

    state_t        state_q, state_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [LW-1:0] len_q, len_d;
    logic [7:0]    cksum_q, cksum_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_cksum_q, err_cksum_d;
    logic          err_len_q, err_len_d;
    logic          err_timeout_q, err_timeout_d;
    logic          err_overrun_q, err_overrun_d;
    logic          buf_we;
    logic          in_frame;
    logic          expired;

    // The inter-byte timer only runs while a frame is partially received.
    assign in_frame = (state_q == ST_CMD) || (state_q == ST_LEN) ||
                      (state_q == ST_PAYLOAD) || (state_q == ST_CHK);
    // A byte arriving on the expiry cycle wins over the timeout.
    assign expired  = in_frame && !uart_done && (cnt_q == TO_LAST);

    // Next-state, checksum, index, timer and error-pulse logic.
    // NOTE: every *_d gets its hold value first so no path leaves a signal
    // unassigned; without those defaults the case below would infer latches.
    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        len_d         = len_q;
        cksum_d       = cksum_q;
        idx_d         = idx_q;
        err_cksum_d   = 1'b0;
        err_len_d     = 1'b0;
        err_timeout_d = 1'b0;
        err_overrun_d = 1'b0;
        buf_we        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (uart_done && (uart_data == FRM_SOF)) begin
                    cksum_d = '0;
                    idx_d   = '0;
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (uart_done) begin
                    cmd_d   = uart_data;
                    cksum_d = uart_data;
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (uart_done) begin
                    cksum_d = cksum_q ^ uart_data;
                    idx_d   = '0;
                    if (uart_data > MAX_LEN8) begin
                        err_len_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        len_d   = uart_data[LW-1:0];
                        state_d = (uart_data == 8'd0) ? ST_CHK : ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (uart_done) begin
                    buf_we  = 1'b1;
                    cksum_d = cksum_q ^ uart_data;
                    idx_d   = idx_q + AW'(1);
                    if (LW'(idx_q) + LW'(1) == len_q) begin
                        state_d = ST_CHK;
                    end
                end
            end
            ST_CHK: begin
                if (uart_done) begin
                    if (uart_data == cksum_q) begin
                        state_d = ST_HOLD;
                    end else begin
                        err_cksum_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                // The held frame stays frozen; any new byte is lost.
                err_overrun_d = uart_done;
                if (frm_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (expired) begin
            err_timeout_d = 1'b1;
            state_d       = ST_IDLE;
        end

        if (!in_frame || uart_done || expired) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Register update with synchronous reset; payload buffer is excluded.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q       <= ST_IDLE;
            cmd_q         <= '0;
            len_q         <= '0;
            cksum_q       <= '0;
            idx_q         <= '0;
            cnt_q         <= '0;
            err_cksum_q   <= 1'b0;
            err_len_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            len_q         <= len_d;
            cksum_q       <= cksum_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            err_cksum_q   <= err_cksum_d;
            err_len_q     <= err_len_d;
            err_timeout_q <= err_timeout_d;
            err_overrun_q <= err_overrun_d;
        end
    end

    uart_frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk   (sys_clk),
        .we    (buf_we),
        .waddr (idx_q),
        .wdata (uart_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign frm_valid   = (state_q == ST_HOLD);
    assign busy        = (state_q != ST_IDLE);
    assign frm_cmd     = cmd_q;
    assign frm_len     = len_q;
    assign err_cksum   = err_cksum_q;
    assign err_len     = err_len_q;
    assign err_timeout = err_timeout_q;
    assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Directed self-checking bench for uart_frame_ctrl at default parameters.
module tb_uart_frame_ctrl;

    localparam int TO_CYC = 17360;  // (50e6/115200 = 434) * 10 * 4

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       uart_done;
    logic [7:0] uart_data;
    logic       frm_valid;
    logic       frm_ready;
    logic [7:0] frm_cmd;
    logic [4:0] frm_len;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;
    logic       err_cksum;
    logic       err_len;
    logic       err_timeout;
    logic       err_overrun;

    int n_checks = 0;
    int n_fail   = 0;

    uart_frame_ctrl dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .uart_done   (uart_done),
        .uart_data   (uart_data),
        .frm_valid   (frm_valid),
        .frm_ready   (frm_ready),
        .frm_cmd     (frm_cmd),
        .frm_len     (frm_len),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .busy        (busy),
        .err_cksum   (err_cksum),
        .err_len     (err_len),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun)
    );

    always #5 sys_clk = ~sys_clk;

    // Strobe one byte after a short gap; returns 1ns after the consuming edge.
    task automatic send_byte(input logic [7:0] b);
        repeat (2) @(posedge sys_clk);
        #1;
        uart_done = 1'b1;
        uart_data = b;
        @(posedge sys_clk);
        #1;
        uart_done = 1'b0;
    endtask

    // Reference frame: CMD 10, LEN 3, payload 11 22 33, CHK = 10^03^11^22^33 = 13.
    task automatic send_std_frame();
        send_byte(8'hA5);
        send_byte(8'h10);
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h13);
    endtask

    task automatic handshake();
        frm_ready = 1'b1;
        @(posedge sys_clk);
        #1;
        frm_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        sys_rst = 1'b1;
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
    endtask

    // All outputs at their reset values.
    task automatic check_idle_outputs(input string tag);
        n_checks++; if (frm_valid !== 1'b0) begin n_fail++; $display("FAIL %s_valid: got %b expected 0", tag, frm_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_busy: got %b expected 0", tag, busy); end
        n_checks++; if (frm_cmd !== 8'h00) begin n_fail++; $display("FAIL %s_cmd: got %h expected 00", tag, frm_cmd); end
        n_checks++; if (frm_len !== 5'd0) begin n_fail++; $display("FAIL %s_len: got %0d expected 0", tag, frm_len); end
        n_checks++; if ({err_cksum, err_len, err_timeout, err_overrun} !== 4'b0000) begin n_fail++; $display("FAIL %s_err: got %b expected 0000", tag, {err_cksum, err_len, err_timeout, err_overrun}); end
    endtask

    task automatic test_reset();
        sys_rst   = 1'b1;
        uart_done = 1'b0;
        uart_data = 8'h00;
        frm_ready = 1'b0;
        rd_addr   = '0;
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        check_idle_outputs("reset");
    endtask

    task automatic test_good_frame();
        logic [7:0] exp_pl [3] = '{8'h11, 8'h22, 8'h33};
        send_byte(8'hA5);
        send_byte(8'h10);
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL good_busy_mid: got %b expected 1", busy); end
        n_checks++; if (frm_valid !== 1'b0) begin n_fail++; $display("FAIL good_valid_early: got %b expected 0", frm_valid); end
        send_byte(8'h13);
        n_checks++; if (frm_valid !== 1'b1) begin n_fail++; $display("FAIL good_valid: got %b expected 1", frm_valid); end
        n_checks++; if (frm_cmd !== 8'h10) begin n_fail++; $display("FAIL good_cmd: got %h expected 10", frm_cmd); end
        n_checks++; if (frm_len !== 5'd3) begin n_fail++; $display("FAIL good_len: got %0d expected 3", frm_len); end
        for (int i = 0; i < 3; i++) begin
            rd_addr = 4'(i);
            #1;
            n_checks++; if (rd_data !== exp_pl[i]) begin n_fail++; $display("FAIL good_rd%0d: got %h expected %h", i, rd_data, exp_pl[i]); end
        end
        handshake();
        n_checks++; if (frm_valid !== 1'b0) begin n_fail++; $display("FAIL good_valid_after_ack: got %b expected 0", frm_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL good_busy_after_ack: got %b expected 0", busy); end
    endtask

    task automatic test_bad_cksum();
        send_byte(8'hA5);
        send_byte(8'h10);
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h00);
        n_checks++; if (err_cksum !== 1'b1) begin n_fail++; $display("FAIL cksum_err: got %b expected 1", err_cksum); end
        n_checks++; if (frm_valid !== 1'b0) begin n_fail++; $display("FAIL cksum_valid: got %b expected 0", frm_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cksum_busy: got %b expected 0", busy); end
        @(posedge sys_clk);
        #1;
        n_checks++; if (err_cksum !== 1'b0) begin n_fail++; $display("FAIL cksum_pulse_width: got %b expected 0", err_cksum); end
    endtask

    task automatic test_length();
        logic [7:0] chk;
        logic [7:0] b;
        // LEN = 0x11 = 17, one above the maximum.
        send_byte(8'hA5);
        send_byte(8'h07);
        send_byte(8'h11);
        n_checks++; if (err_len !== 1'b1) begin n_fail++; $display("FAIL len_err: got %b expected 1", err_len); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL len_err_busy: got %b expected 0", busy); end
        @(posedge sys_clk);
        #1;
        n_checks++; if (err_len !== 1'b0) begin n_fail++; $display("FAIL len_pulse_width: got %b expected 0", err_len); end
        // LEN = 0: CHK = 07 ^ 00 = 07.
        send_byte(8'hA5);
        send_byte(8'h07);
        send_byte(8'h00);
        send_byte(8'h07);
        n_checks++; if (frm_valid !== 1'b1) begin n_fail++; $display("FAIL len0_valid: got %b expected 1", frm_valid); end
        n_checks++; if (frm_len !== 5'd0) begin n_fail++; $display("FAIL len0_len: got %0d expected 0", frm_len); end
        n_checks++; if (frm_cmd !== 8'h07) begin n_fail++; $display("FAIL len0_cmd: got %h expected 07", frm_cmd); end
        handshake();
        // LEN = 16, the largest legal frame; payload byte i = 3*i + 1.
        chk = 8'h01 ^ 8'h10;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h10);
        for (int i = 0; i < 16; i++) begin
            b   = 8'(3 * i + 1);
            chk = chk ^ b;
            send_byte(b);
        end
        send_byte(chk);
        n_checks++; if (frm_valid !== 1'b1) begin n_fail++; $display("FAIL len16_valid: got %b expected 1", frm_valid); end
        n_checks++; if (frm_len !== 5'd16) begin n_fail++; $display("FAIL len16_len: got %0d expected 16", frm_len); end
        rd_addr = 4'd15;
        #1;
        n_checks++; if (rd_data !== 8'h2E) begin n_fail++; $display("FAIL len16_rd15: got %h expected 2e", rd_data); end
        rd_addr = 4'd0;
        #1;
        n_checks++; if (rd_data !== 8'h01) begin n_fail++; $display("FAIL len16_rd0: got %h expected 01", rd_data); end
        handshake();
    endtask

    task automatic test_timeout();
        send_byte(8'hA5);
        send_byte(8'h10);
        repeat (TO_CYC - 1) @(posedge sys_clk);
        #1;
        n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got %b expected 0", err_timeout); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL timeout_busy_before: got %b expected 1", busy); end
        @(posedge sys_clk);
        #1;
        n_checks++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b expected 1", err_timeout); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy_after: got %b expected 0", busy); end
        @(posedge sys_clk);
        #1;
        n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse_width: got %b expected 0", err_timeout); end
        send_std_frame();
        n_checks++; if (frm_valid !== 1'b1) begin n_fail++; $display("FAIL timeout_recover_valid: got %b expected 1", frm_valid); end
        n_checks++; if (frm_len !== 5'd3) begin n_fail++; $display("FAIL timeout_recover_len: got %0d expected 3", frm_len); end
        handshake();
    endtask

    task automatic test_overrun();
        send_byte(8'h00);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL garbage_busy: got %b expected 0", busy); end
        send_byte(8'hFF);
        send_std_frame();
        n_checks++; if (frm_valid !== 1'b1) begin n_fail++; $display("FAIL garbage_then_valid: got %b expected 1", frm_valid); end
        send_byte(8'h55);
        n_checks++; if (err_overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_err: got %b expected 1", err_overrun); end
        n_checks++; if (frm_valid !== 1'b1) begin n_fail++; $display("FAIL overrun_valid: got %b expected 1", frm_valid); end
        n_checks++; if (frm_cmd !== 8'h10) begin n_fail++; $display("FAIL overrun_cmd: got %h expected 10", frm_cmd); end
        n_checks++; if (frm_len !== 5'd3) begin n_fail++; $display("FAIL overrun_len: got %0d expected 3", frm_len); end
        rd_addr = 4'd0;
        #1;
        n_checks++; if (rd_data !== 8'h11) begin n_fail++; $display("FAIL overrun_rd0: got %h expected 11", rd_data); end
        @(posedge sys_clk);
        #1;
        n_checks++; if (err_overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_pulse_width: got %b expected 0", err_overrun); end
        // Byte arriving on the handshake cycle is also an overrun.
        frm_ready = 1'b1;
        uart_done = 1'b1;
        uart_data = 8'h66;
        @(posedge sys_clk);
        #1;
        frm_ready = 1'b0;
        uart_done = 1'b0;
        n_checks++; if (err_overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_ack_err: got %b expected 1", err_overrun); end
        n_checks++; if (frm_valid !== 1'b0) begin n_fail++; $display("FAIL overrun_ack_valid: got %b expected 0", frm_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL overrun_ack_busy: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        send_byte(8'hA5);
        send_byte(8'h10);
        send_byte(8'h03);
        send_byte(8'h11);
        pulse_reset();
        check_idle_outputs("rst_payload");
        send_std_frame();
        n_checks++; if (frm_valid !== 1'b1) begin n_fail++; $display("FAIL rst_hold_pre_valid: got %b expected 1", frm_valid); end
        pulse_reset();
        check_idle_outputs("rst_hold");
        send_std_frame();
        n_checks++; if (frm_valid !== 1'b1) begin n_fail++; $display("FAIL rst_recover_valid: got %b expected 1", frm_valid); end
        n_checks++; if (frm_cmd !== 8'h10) begin n_fail++; $display("FAIL rst_recover_cmd: got %h expected 10", frm_cmd); end
        rd_addr = 4'd2;
        #1;
        n_checks++; if (rd_data !== 8'h33) begin n_fail++; $display("FAIL rst_recover_rd2: got %h expected 33", rd_data); end
        handshake();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_recover_busy: got %b expected 0", busy); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_cksum();
        test_length();
        test_timeout();
        test_overrun();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
